// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit_pkg
// Purpose  : Shared RISC-V definitions for the load/store unit: RV32I width
//            codes (funct3), FSM state encoding and request-check helpers.
// Revision : 1.0 - initial release
// ============================================================================
package load_store_unit_pkg;

    // RV32I load/store width codes carried in funct3
    localparam logic [2:0] c_f3_b  = 3'b000;
    localparam logic [2:0] c_f3_h  = 3'b001;
    localparam logic [2:0] c_f3_w  = 3'b010;
    localparam logic [2:0] c_f3_bu = 3'b100;
    localparam logic [2:0] c_f3_hu = 3'b101;

    // Load/store sequencing states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LD    = 3'd1,
        ST_RD = 3'd2,
        ST_WR = 3'd3,
        RESP  = 3'd4
    } lsu_state_t;

    // Unsigned widths exist only for loads; anything outside the five codes
    // is illegal in both directions.
    function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
        case (f3)
            c_f3_b, c_f3_h, c_f3_w: return 1'b0;
            c_f3_bu, c_f3_hu:       return is_store;
            default:                return 1'b1;
        endcase
    endfunction

    // Halves need an even address, words a 4-byte aligned one.
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] byte_off);
        case (f3)
            c_f3_h, c_f3_hu: return byte_off[0];
            c_f3_w:          return |byte_off;
            default:         return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_load_extend.sv
`default_nettype none
// ============================================================================
// Module   : load_extend
// Purpose  : Selects the byte/half/word lane of a memory word addressed by
//            the low address bits and sign- or zero-extends it to 32 bits.
// Revision : 1.0 - initial release
// ============================================================================
module load_extend
    import load_store_unit_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  byte_off,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] w_shifted;

    // Move the addressed lane down to bit 0, then extend by width code
    always_comb begin
        w_shifted = word >> {byte_off, 3'b000};
        data      = '0;
        case (funct3)
            c_f3_b:  data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            c_f3_h:  data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            c_f3_w:  data = w_shifted;
            c_f3_bu: data = {24'd0, w_shifted[7:0]};
            c_f3_hu: data = {16'd0, w_shifted[15:0]};
            default: data = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : RV32I load/store unit between the pipeline request interface and
//            a word-addressed data memory. Loads take one memory read, word
//            stores one write, sub-word stores a read-modify-write. Misaligned
//            or illegal requests respond with an error and touch no memory.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int WORD_IDX_BITS = 6
) (
    input  logic        clk,
    input  logic        reset,
    // pipeline request
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    // pipeline response
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    // data memory word interface
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] Address,
    output logic [31:0] write_data,
    input  logic [31:0] Read_data
);

    lsu_state_t                 r_state;
    lsu_state_t                 w_state_next;

    // Captured request fields
    logic                       r_store;
    logic [2:0]                 r_funct3;
    logic [WORD_IDX_BITS+1:0]   r_addr;
    logic [31:0]                r_wdata;
    logic                       r_err;

    // Old memory word for read-modify-write, and the registered load result
    logic [31:0]                r_rd_word;
    logic [31:0]                r_rdata;

    logic                       w_accept;
    logic                       w_req_err;
    logic [31:0]                w_load_data;
    logic [31:0]                w_merged;
    logic                       w_unused;

    // Address bits above the memory's word index never reach the memory
    assign w_unused  = &{1'b0, req_addr[31:WORD_IDX_BITS+2]};

    assign w_accept  = req_valid & req_ready;
    assign w_req_err = f3_illegal(req_store, req_funct3)
                     | f3_misaligned(req_funct3, req_addr[1:0]);

    // State register; reset abandons whatever operation is in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and strobe decode
    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (w_req_err) begin
                        w_state_next = RESP;
                    end else if (!req_store) begin
                        w_state_next = LD;
                    end else if (req_funct3 == c_f3_w) begin
                        w_state_next = ST_WR;
                    end else begin
                        w_state_next = ST_RD;
                    end
                end
            end
            LD: begin
                MemRead      = 1'b1;
                w_state_next = RESP;
            end
            ST_RD: begin
                MemRead      = 1'b1;
                w_state_next = ST_WR;
            end
            ST_WR: begin
                MemWrite     = r_store;
                w_state_next = RESP;
            end
            RESP: begin
                resp_valid   = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Capture the request on accept, then the load result or the RMW word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_store   <= 1'b0;
            r_funct3  <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_err     <= 1'b0;
            r_rd_word <= '0;
            r_rdata   <= '0;
        end else begin
            if (w_accept) begin
                r_store  <= req_store;
                r_funct3 <= req_funct3;
                r_addr   <= req_addr[WORD_IDX_BITS+1:0];
                r_wdata  <= req_wdata;
                r_err    <= w_req_err;
                // stores and errors respond with zero data
                r_rdata  <= '0;
            end
            if (r_state == LD) begin
                r_rdata <= w_load_data;
            end
            if (r_state == ST_RD) begin
                r_rd_word <= Read_data;
            end
        end
    end

    load_extend u_load_extend (
        .word     (Read_data),
        .byte_off (r_addr[1:0]),
        .funct3   (r_funct3),
        .data     (w_load_data)
    );

    // Insert the new byte/half into the old word; a word store replaces it
    always_comb begin
        w_merged = r_rd_word;
        case (r_funct3)
            c_f3_b: begin
                w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
            end
            c_f3_h: begin
                if (r_addr[1]) begin
                    w_merged[31:16] = r_wdata[15:0];
                end else begin
                    w_merged[15:0]  = r_wdata[15:0];
                end
            end
            default: begin
                w_merged = r_wdata;
            end
        endcase
    end

    // Memory buses are quiet (zero) whenever their strobe is low
    assign Address    = (MemRead | MemWrite)
                      ? {{(32-WORD_IDX_BITS){1'b0}}, r_addr[WORD_IDX_BITS+1:2]}
                      : '0;
    assign write_data = MemWrite ? w_merged : '0;

    assign resp_rdata = resp_valid ? r_rdata : '0;
    assign resp_err   = resp_valid & r_err;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Scoreboard bench for load_store_unit: driver pushes expected
//            responses from a behavioural model, monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] write_data;
    logic [31:0] Read_data;

    load_store_unit #(.WORD_IDX_BITS(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Address    (Address),
        .write_data (write_data),
        .Read_data  (Read_data)
    );

    always #5 clk = ~clk;

    // Data memory (async read, sync write) and its reference image
    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];
    logic        init_copy;

    assign Read_data = mem[Address[5:0]];

    always @(posedge clk) begin
        if (init_copy) begin
            for (int i = 0; i < 64; i++) mem[i] <= ref_mem[i];
        end else if (MemWrite) begin
            mem[Address[5:0]] <= write_data;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
        int          nrd;
        int          nwr;
        logic [31:0] idx;
        logic [31:0] wdata;
    } exp_t;

    exp_t q[$];

    // Behavioural reference: expected response, strobes, latency, memory effect
    task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int k, output exp_t e);
        int          size;
        bit          legal;
        int          off;
        int          idx;
        logic [31:0] v;
        logic [31:0] mask;
        logic [31:0] nw;
        legal   = st ? (f3 <= 3'd2) : (f3 <= 3'd5 && f3 != 3'd3);
        size    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off     = int'(a % 4);
        idx     = int'((a / 4) % 64);
        e.err   = !legal || (off % size != 0);
        e.idx   = idx;
        e.rdata = 0;
        e.wdata = 0;
        e.nrd   = 0;
        e.nwr   = 0;
        if (e.err) begin
            e.due = k + 1;
        end else if (!st) begin
            v = ref_mem[idx] >> (8 * off);
            if (size == 1) begin
                v = v % 256;
                if (f3 == 3'd0 && v >= 128) v = v - 256;
            end else if (size == 2) begin
                v = v % 65536;
                if (f3 == 3'd1 && v >= 32768) v = v - 65536;
            end
            e.rdata = v;
            e.nrd   = 1;
            e.due   = k + 2;
        end else begin
            if (size == 4) begin
                nw    = wd;
                e.due = k + 2;
            end else begin
                mask  = ((size == 1) ? 32'hFF : 32'hFFFF) << (8 * off);
                nw    = (ref_mem[idx] & ~mask) | ((wd << (8 * off)) & mask);
                e.nrd = 1;
                e.due = k + 3;
            end
            e.nwr        = 1;
            e.wdata      = nw;
            ref_mem[idx] = nw;
        end
    endtask

    // Values last observed on the DUT, for the directed checks
    logic [31:0] last_rdata;
    logic        last_err;
    int          last_resp_cyc;
    logic [31:0] last_rd_addr;
    logic [31:0] last_wr_addr;
    logic [31:0] last_wr_data;
    int          nrd = 0;
    int          nwr = 0;

    // Monitor: bus hygiene every cycle, scoreboard pop on each response
    always @(negedge clk) begin
        if (reset) begin
            nrd = 0;
            nwr = 0;
        end else begin
            if (MemRead || MemWrite) begin
                chk("strobe_exclusive", {31'd0, MemRead & MemWrite}, 32'd0);
                chk("strobe_owner", q.size(), 32'd1);
                if (q.size() != 0) begin
                    chk("address", Address, q[0].idx);
                    if (MemRead) begin
                        nrd++;
                        last_rd_addr = Address;
                    end
                    if (MemWrite) begin
                        nwr++;
                        last_wr_addr = Address;
                        last_wr_data = write_data;
                        chk("write_data", write_data, q[0].wdata);
                    end
                end
            end else begin
                chk("idle_address", Address, 32'd0);
                chk("idle_write_data", write_data, 32'd0);
            end
            if (resp_valid) begin
                chk("resp_owner", q.size(), 32'd1);
                last_rdata    = resp_rdata;
                last_err      = resp_err;
                last_resp_cyc = cyc;
                if (q.size() != 0) begin
                    chk("resp_rdata", resp_rdata, q[0].rdata);
                    chk("resp_err", {31'd0, resp_err}, {31'd0, q[0].err});
                    chk("resp_cycle", cyc, q[0].due);
                    chk("read_strobes", nrd, q[0].nrd);
                    chk("write_strobes", nwr, q[0].nwr);
                    void'(q.pop_front());
                end
                nrd = 0;
                nwr = 0;
            end
        end
    end

    bit b2b      = 0;
    int prev_due = 0;
    int last_acc = 0;

    // Present one request at a negedge and return at the negedge after accept
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input bit hold);
        exp_t e;
        int   n;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        n = 0;
        while (!req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", {31'd0, req_ready}, 32'd1);
        if (!req_ready) begin
            req_valid = 1'b0;
            b2b       = 0;
            return;
        end
        if (b2b) chk("b2b_accept_cycle", cyc, prev_due + 1);
        last_acc = cyc;
        model(st, f3, a, wd, cyc, e);
        q.push_back(e);
        prev_due = e.due;
        @(posedge clk);
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
        b2b = hold;
    endtask

    task automatic drain();
        int n;
        req_valid = 1'b0;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("drain", q.size(), 32'd0);
        @(negedge clk);
        b2b = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        for (int i = 0; i < 64; i++) ref_mem[i] = $urandom;
        ref_mem[3] = 32'h8899AABB;
        init_copy  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        init_copy = 1'b0;
        reset     = 1'b0;
        #1;
        chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("reset_memread", {31'd0, MemRead}, 32'd0);
        chk("reset_memwrite", {31'd0, MemWrite}, 32'd0);
        chk("reset_resp_rdata", resp_rdata, 32'd0);
        @(negedge clk);

        // LB / LBU from word 3
        issue(1'b0, 3'b000, 32'h0000_000D, 32'd0, 1'b0);
        drain();
        chk("lb_address", last_rd_addr, 32'd3);
        chk("lb_rdata", last_rdata, 32'hFFFF_FFAA);
        chk("lb_latency", last_resp_cyc - last_acc, 32'd2);
        issue(1'b0, 3'b100, 32'h0000_000D, 32'd0, 1'b0);
        drain();
        chk("lbu_rdata", last_rdata, 32'h0000_00AA);

        // SW then LW
        issue(1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
        drain();
        chk("sw_address", last_wr_addr, 32'd4);
        chk("sw_write_data", last_wr_data, 32'hDEAD_BEEF);
        issue(1'b0, 3'b010, 32'h0000_0010, 32'd0, 1'b0);
        drain();
        chk("lw_rdata", last_rdata, 32'hDEAD_BEEF);

        // SH read-modify-write into word 4
        issue(1'b1, 3'b001, 32'h0000_0012, 32'h0000_1234, 1'b0);
        drain();
        chk("sh_write_data", last_wr_data, 32'h1234_BEEF);
        chk("sh_latency", last_resp_cyc - last_acc, 32'd3);

        // Misaligned LW
        issue(1'b0, 3'b010, 32'h0000_0006, 32'd0, 1'b0);
        drain();
        chk("lw_mis_err", {31'd0, last_err}, 32'd1);
        chk("lw_mis_latency", last_resp_cyc - last_acc, 32'd1);

        // Reset during ST_RD of an SB to word 8
        req_store  = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h0000_0021;
        req_wdata  = 32'h0000_0055;
        req_valid  = 1'b1;
        e.rdata = 0; e.err = 0; e.due = cyc + 3; e.nrd = 1; e.nwr = 1;
        e.idx = 32'd8; e.wdata = 32'd0;
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("sb_st_rd_memread", {31'd0, MemRead}, 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("rst_memread", {31'd0, MemRead}, 32'd0);
        chk("rst_memwrite", {31'd0, MemWrite}, 32'd0);
        chk("rst_address", Address, 32'd0);
        chk("rst_write_data", write_data, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        q.delete();
        @(posedge clk);
        @(negedge clk);
        #1 reset = 1'b0;
        chk("rst_release_ready", {31'd0, req_ready}, 32'd1);
        repeat (4) @(negedge clk);
        chk("rst_mem_unchanged", mem[8], ref_mem[8]);

        // Randomized traffic, mostly back-to-back with req_valid held
        for (int t = 0; t < 80; t++) begin
            logic        st;
            logic [2:0]  f3;
            logic [31:0] a;
            st = 1'($urandom_range(0, 1));
            f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7))
                                             : (st ? 3'($urandom_range(0, 2))
                                                   : ((f3_pick() )));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                // bias toward aligned addresses so most requests succeed
                a[1:0] = (f3[1:0] == 2'd2) ? 2'd0 : (f3[1:0] == 2'd1) ? {a[1], 1'b0} : a[1:0];
            end
            issue(st, f3, a, $urandom, ($urandom_range(0, 4) != 0));
        end
        drain();

        for (int i = 0; i < 64; i++) chk("final_mem", mem[i], ref_mem[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Random legal load width code
    function automatic logic [2:0] f3_pick();
        logic [2:0] codes [5];
        codes[0] = 3'b000;
        codes[1] = 3'b001;
        codes[2] = 3'b010;
        codes[3] = 3'b100;
        codes[4] = 3'b101;
        return codes[$urandom_range(0, 4)];
    endfunction

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter WORD_IDX_BITS, default 6, meaning the number of word-index bits driven to data memory (64 words).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-004 SHALL have port req_valid, input, 1: the pipeline presents a memory request.
REQ-005 SHALL have port req_ready, output, 1: the unit accepts a request this cycle.
REQ-006 SHALL have port req_store, input, 1: 1 = store, 0 = load.
REQ-007 SHALL have port req_funct3, input, 3: RV32I width code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-008 SHALL have port req_addr, input, 32: byte address.
REQ-009 SHALL have port req_wdata, input, 32: store data, right-aligned.
REQ-010 SHALL have port resp_valid, output, 1: one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata, output, 32: extended load result, valid with resp_valid.
REQ-012 SHALL have port resp_err, output, 1: misaligned or illegal funct3, valid with resp_valid.
REQ-013 SHALL have ports MemRead, output, 1; MemWrite, output, 1; Address, output, 32; write_data, output, 32; Read_data, input, 32, matching data memory's word interface.

Function
REQ-014 SHALL implement the FSM states IDLE, LD, ST_RD, ST_WR and RESP.
REQ-015 SHALL drive req_ready=1 only in IDLE; accept occurs on req_valid&&req_ready and registers all req_* fields.
REQ-016 SHALL flag an error if funct3 is illegal for the direction, H/HU has addr[0]!=0, or W has addr[1:0]!=0; an error SHALL go IDLE->RESP with no memory strobe.
REQ-017 SHALL drive Address = zero-extended addr[WORD_IDX_BITS+1:2] whenever MemRead or MemWrite is high, and 0 otherwise.
REQ-018 SHALL handle a load as IDLE->LD->RESP: in LD assert MemRead, select the byte/half addressed by addr[1:0], extend it (B/H sign-extend, BU/HU zero-extend) and register it into resp_rdata.
REQ-019 SHALL handle a word store as IDLE->ST_WR->RESP: in ST_WR assert MemWrite with write_data=req_wdata.
REQ-020 SHALL handle a byte/half store as a read-modify-write, IDLE->ST_RD->ST_WR->RESP: ST_RD asserts MemRead and registers Read_data; ST_WR merges the new lane(s) at addr[1:0] into that word and asserts MemWrite.
REQ-021 SHALL never assert MemRead and MemWrite in the same cycle; write_data SHALL be 0 when MemWrite=0.
REQ-022 SHALL assert resp_valid in RESP for exactly one cycle, then return to IDLE; a new request can be accepted the following cycle.
REQ-023 SHALL give resp_rdata=0 for stores and error responses.
REQ-024 SHALL have latency from accept to resp_valid of 2 cycles for a load or word store, 3 for a sub-word store, and 1 for an error.
REQ-025 SHALL ignore req_* inputs outside an IDLE accept.

Reset
REQ-026 SHALL, on reset assertion at any time, force the state to IDLE and asynchronously clear resp_valid, resp_rdata, resp_err, MemRead, MemWrite, Address and write_data.
REQ-027 SHALL abandon any in-flight operation on reset, with no later MemWrite or resp_valid for it.
REQ-028 SHALL have req_ready=1 in the first cycle after reset deasserts.

Structure
REQ-029 SHALL place the funct3 width codes and FSM state encodings in the shared riscv package.
REQ-030 SHALL contain one combinational sub-module, load_extend (lane select plus sign/zero extend); the store-merge logic SHALL stay inline.

Verification
REQ-031 SHALL check: memory word 3 = 0x8899AABB, LB addr 0x0D -> Address=3, resp_rdata=0xFFFFFFAA after 2 cycles; LBU -> 0x000000AA.
REQ-032 SHALL check: SW addr 0x10, data 0xDEADBEEF -> one MemWrite cycle with Address=4, write_data=0xDEADBEEF; a later LW returns 0xDEADBEEF.
REQ-033 SHALL check: word 4 = 0xDEADBEEF, SH addr 0x12, data 0x00001234 -> MemRead then MemWrite, write_data=0x1234BEEF, resp_valid at cycle 3.
REQ-034 SHALL check: LW addr 0x06 -> resp_err=1 one cycle after accept, with MemRead and MemWrite never asserted.
REQ-035 SHALL check: reset asserted during ST_RD of an SB -> outputs clear immediately, no MemWrite occurs, req_ready=1 after release, and memory is unchanged.
REQ-036 SHALL check: back-to-back requests with req_valid held high -> each is accepted on the cycle after the previous resp_valid, and MemRead and MemWrite are never both high.
